// File: rtl/carfield_cfg_pkg.sv
// Carfield-wide configuration constants: number of clock domains and the
// index assigned to each domain.
package carfield_cfg_pkg;

    localparam int unsigned CarfieldNumDomains = 6;

    // Domain order: periph, safed, secured, pulp, spatz, l2
    localparam int unsigned CarfieldDomainIdx [CarfieldNumDomains] = '{0, 1, 2, 3, 4, 5};

endpackage

// File: rtl/carfield_domain_seq_pkg.sv
// Types and defaults shared by the per-domain clock/reset sequencer.
package carfield_domain_seq_pkg;

    import carfield_cfg_pkg::*;

    localparam int unsigned SeqNumDomains = CarfieldNumDomains;
    localparam int unsigned SeqDivWidth   = 8;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        CFG,
        SETTLE,
        RUN_RST,
        DONE
    } seq_state_e;

    typedef logic [$clog2(SeqNumDomains)-1:0] dom_idx_t;
    typedef logic [SeqDivWidth-1:0]           div_t;

endpackage

// File: rtl/carfield_domain_seq_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves to grant+1 when the grant is accepted.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_i          : per-requester request
//   accept_i       : grant consumed this cycle, advance the pointer
//   gnt_vld_c_o    : some requester is granted (combinational)
//   gnt_idx_c_o    : granted index (combinational)
module carfield_domain_seq_arb
    import carfield_domain_seq_pkg::*;
#(
    parameter int unsigned NumReq = SeqNumDomains
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic                      accept_i,
    output logic                      gnt_vld_c_o,
    output logic [$clog2(NumReq)-1:0] gnt_idx_c_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] ptr_q, ptr_d;

    // Scan from the pointer, wrapping once around the requesters
    always_comb begin
        int unsigned j;
        gnt_vld_c_o = 1'b0;
        gnt_idx_c_o = '0;
        j           = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            if (!gnt_vld_c_o && req_i[IdxW'(j)]) begin
                gnt_vld_c_o = 1'b1;
                gnt_idx_c_o = IdxW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && gnt_vld_c_o) begin
            ptr_d = (gnt_idx_c_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_c_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/carfield_domain_seq.sv
// Per-domain clock/reset sequencer. Serves one domain request at a time:
// gate clock, program divider, settle, ungate, optionally pulse domain reset.
// Optional macro CARFIELD_DOMAIN_SEQ_TIMEOUT_EN bounds the divider handshake.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_valid_i    : per-domain request;  req_ready_o: one-cycle completion
//   req_div_i      : requested divider per domain; req_rst_i: also reset domain
//   clk_en_o       : clock gate enables;  dom_rst_o: domain resets
//   div_o          : divider values;  div_valid_o/div_ready_i: divider handshake
//   busy_o         : sequence in flight;  active_dom_o: granted domain
//   err_o          : one-cycle error pulse (zero divider / handshake timeout)
module carfield_domain_seq
    import carfield_domain_seq_pkg::*;
#(
    parameter int unsigned NumDomains    = SeqNumDomains,
    parameter int unsigned DivWidth      = SeqDivWidth,
    parameter int unsigned DefaultDiv    = 1,
    parameter int unsigned GateCycles    = 4,
    parameter int unsigned RstCycles     = 8,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumDomains-1:0]            req_valid_i,
    output logic [NumDomains-1:0]            req_ready_o,
    input  logic [NumDomains*DivWidth-1:0]   req_div_i,
    input  logic [NumDomains-1:0]            req_rst_i,
    output logic [NumDomains-1:0]            clk_en_o,
    output logic [NumDomains-1:0]            dom_rst_o,
    output logic [NumDomains*DivWidth-1:0]   div_o,
    output logic [NumDomains-1:0]            div_valid_o,
    input  logic [NumDomains-1:0]            div_ready_i,
    output logic                             busy_o,
    output logic [$clog2(NumDomains)-1:0]    active_dom_o,
    output logic                             err_o
);

    localparam int unsigned IdxW   = $clog2(NumDomains);
    localparam int unsigned MaxGR  = (GateCycles > RstCycles) ? GateCycles : RstCycles;
    localparam int unsigned MaxCyc = (MaxGR > TimeoutCycles) ? MaxGR : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    seq_state_e                  state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [IdxW-1:0]             dom_q, dom_d;
    logic [DivWidth-1:0]         div_cap_q, div_cap_d;
    logic                        rst_flag_q, rst_flag_d;
    logic [NumDomains-1:0]       clk_en_q, clk_en_d;
    logic [NumDomains-1:0]       dom_rst_q, dom_rst_d;
    logic [DivWidth-1:0]         div_q [NumDomains];
    logic [DivWidth-1:0]         div_d [NumDomains];
    logic [NumDomains-1:0]       div_valid_q, div_valid_d;
    logic [NumDomains-1:0]       ready_q, ready_d;
    logic                        err_q, err_d;
    logic                        busy_q;

    logic [DivWidth-1:0]         req_div_a [NumDomains];
    logic                        accept_c;
    logic                        gnt_vld_c;
    logic [IdxW-1:0]             gnt_idx_c;

    // Flat bus <-> per-domain arrays
    for (genvar g = 0; g < NumDomains; g++) begin : g_dom
        assign req_div_a[g]                    = req_div_i[g*DivWidth +: DivWidth];
        assign div_o[g*DivWidth +: DivWidth]   = div_q[g];
    end

    carfield_domain_seq_arb #(
        .NumReq (NumDomains)
    ) i_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_valid_i),
        .accept_i    (accept_c),
        .gnt_vld_c_o (gnt_vld_c),
        .gnt_idx_c_o (gnt_idx_c)
    );

    // Next-state and next-output logic; outputs change on state transitions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dom_d       = dom_q;
        div_cap_d   = div_cap_q;
        rst_flag_d  = rst_flag_q;
        clk_en_d    = clk_en_q;
        dom_rst_d   = dom_rst_q;
        div_d       = div_q;
        div_valid_d = div_valid_q;
        ready_d     = '0;
        err_d       = 1'b0;
        accept_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld_c) begin
                    accept_c   = 1'b1;
                    dom_d      = gnt_idx_c;
                    div_cap_d  = req_div_a[gnt_idx_c];
                    rst_flag_d = req_rst_i[gnt_idx_c];
                    cnt_d      = '0;
                    if (req_div_a[gnt_idx_c] == '0) begin
                        // Zero divider: reject without touching the domain
                        ready_d[gnt_idx_c] = 1'b1;
                        err_d              = 1'b1;
                        state_d            = DONE;
                    end else begin
                        clk_en_d[gnt_idx_c] = 1'b0;
                        if (req_rst_i[gnt_idx_c]) begin
                            dom_rst_d[gnt_idx_c] = 1'b1;
                        end
                        state_d = GATE;
                    end
                end
            end
            GATE: begin
                if (cnt_q == CntW'(GateCycles - 1)) begin
                    cnt_d              = '0;
                    div_d[dom_q]       = div_cap_q;
                    div_valid_d[dom_q] = 1'b1;
                    state_d            = CFG;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            CFG: begin
                if (div_ready_i[dom_q]) begin
                    cnt_d              = '0;
                    div_valid_d[dom_q] = 1'b0;
                    state_d            = SETTLE;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    // Divider never answered: release the clock and report
                    div_valid_d[dom_q] = 1'b0;
                    clk_en_d[dom_q]    = 1'b1;
                    ready_d[dom_q]     = 1'b1;
                    err_d              = 1'b1;
                    state_d            = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == CntW'(GateCycles - 1)) begin
                    cnt_d           = '0;
                    clk_en_d[dom_q] = 1'b1;
                    if (rst_flag_q) begin
                        state_d = RUN_RST;
                    end else begin
                        ready_d[dom_q] = 1'b1;
                        state_d        = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RUN_RST: begin
                if (cnt_q == CntW'(RstCycles - 1)) begin
                    cnt_d            = '0;
                    dom_rst_d[dom_q] = 1'b0;
                    ready_d[dom_q]   = 1'b1;
                    state_d          = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dom_q       <= '0;
            div_cap_q   <= '0;
            rst_flag_q  <= 1'b0;
            clk_en_q    <= '0;
            dom_rst_q   <= '1;
            for (int i = 0; i < NumDomains; i++) begin
                div_q[i] <= DivWidth'(DefaultDiv);
            end
            div_valid_q <= '0;
            ready_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dom_q       <= dom_d;
            div_cap_q   <= div_cap_d;
            rst_flag_q  <= rst_flag_d;
            clk_en_q    <= clk_en_d;
            dom_rst_q   <= dom_rst_d;
            div_q       <= div_d;
            div_valid_q <= div_valid_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req_ready_o  = ready_q;
    assign clk_en_o     = clk_en_q;
    assign dom_rst_o    = dom_rst_q;
    assign div_valid_o  = div_valid_q;
    assign busy_o       = busy_q;
    assign active_dom_o = dom_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_carfield_domain_seq.sv
// Directed bench for carfield_domain_seq (6 domains, 8-bit dividers,
// GateCycles=4, RstCycles=8, TimeoutCycles=16).
module tb_carfield_domain_seq;

    localparam int unsigned N  = 6;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*DW-1:0]   req_div_i;
    logic [N-1:0]      req_rst_i;
    logic [N-1:0]      clk_en_o;
    logic [N-1:0]      dom_rst_o;
    logic [N*DW-1:0]   div_o;
    logic [N-1:0]      div_valid_o;
    logic [N-1:0]      div_ready_i;
    logic              busy_o;
    logic [2:0]        active_dom_o;
    logic              err_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    carfield_domain_seq #(
        .NumDomains    (6),
        .DivWidth      (8),
        .DefaultDiv    (1),
        .GateCycles    (4),
        .RstCycles     (8),
        .TimeoutCycles (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_div_i    (req_div_i),
        .req_rst_i    (req_rst_i),
        .clk_en_o     (clk_en_o),
        .dom_rst_o    (dom_rst_o),
        .div_o        (div_o),
        .div_valid_o  (div_valid_o),
        .div_ready_i  (div_ready_i),
        .busy_o       (busy_o),
        .active_dom_o (active_dom_o),
        .err_o        (err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N*DW-1:0] exp_div;
        exp_div = {6{8'd1}};
        rst_i = 1'b1;
        step();
        step();
        vectors++;
        if (clk_en_o !== 6'h00) begin
            miscompares++; $display("FAIL reset_clk_en: got %h exp 00", clk_en_o);
        end
        vectors++;
        if (dom_rst_o !== 6'h3f) begin
            miscompares++; $display("FAIL reset_dom_rst: got %h exp 3f", dom_rst_o);
        end
        vectors++;
        if (div_o !== exp_div) begin
            miscompares++; $display("FAIL reset_div: got %h exp %h", div_o, exp_div);
        end
        vectors++;
        if ({div_valid_o, req_ready_o, busy_o, active_dom_o, err_o} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_misc: got valid=%h ready=%h busy=%b dom=%0d err=%b exp all 0",
                     div_valid_o, req_ready_o, busy_o, active_dom_o, err_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_single();
        int rdy_k   = -1;
        int low_cnt = 0;
        req_div_i[2*DW +: DW] = 8'd3;
        req_rst_i             = '0;
        req_valid_i[2]        = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) begin
                vectors++;
                if (active_dom_o !== 3'd2 || busy_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_grant: got dom=%0d busy=%b exp dom=2 busy=1", active_dom_o, busy_o);
                end
            end
            if (clk_en_o[2] === 1'b0) low_cnt++;
            if (req_ready_o[2] === 1'b1) begin
                rdy_k = k;
                req_valid_i[2] = 1'b0;
                break;
            end
        end
        vectors++;
        if (rdy_k != 10) begin
            miscompares++; $display("FAIL single_ready_latency: got %0d exp 10", rdy_k);
        end
        vectors++;
        if (low_cnt != 9) begin
            miscompares++; $display("FAIL single_gated_cycles: got %0d exp 9", low_cnt);
        end
        vectors++;
        if (div_o[2*DW +: DW] !== 8'd3 || clk_en_o[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_div_clk: got div=%0d clk_en=%b exp div=3 clk_en=1", div_o[2*DW +: DW], clk_en_o[2]);
        end
        vectors++;
        if (dom_rst_o !== 6'h3f || err_o !== 1'b0) begin
            miscompares++; $display("FAIL single_rst_err: got rst=%h err=%b exp rst=3f err=0", dom_rst_o, err_o);
        end
        step();
        vectors++;
        if (busy_o !== 1'b0 || req_ready_o !== 6'h00) begin
            miscompares++; $display("FAIL single_idle: got busy=%b ready=%h exp 0 00", busy_o, req_ready_o);
        end
    endtask

    task automatic test_rst_bringup();
        int rdy_k   = -1;
        int run_cnt = 0;
        req_div_i[0 +: DW] = 8'd1;
        req_rst_i[0]       = 1'b1;
        req_valid_i[0]     = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (dom_rst_o[0] === 1'b1 && clk_en_o[0] === 1'b1) run_cnt++;
            if (req_ready_o[0] === 1'b1) begin
                rdy_k = k;
                req_valid_i[0] = 1'b0;
                break;
            end
        end
        req_rst_i[0] = 1'b0;
        vectors++;
        if (rdy_k != 18) begin
            miscompares++; $display("FAIL bringup_ready_latency: got %0d exp 18", rdy_k);
        end
        vectors++;
        if (run_cnt != 8) begin
            miscompares++; $display("FAIL bringup_rst_hold: got %0d exp 8", run_cnt);
        end
        vectors++;
        if (dom_rst_o[0] !== 1'b0 || clk_en_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bringup_done: got rst=%b clk_en=%b exp rst=0 clk_en=1", dom_rst_o[0], clk_en_o[0]);
        end
        step();
    endtask

    task automatic test_contention();
        int ord [4];
        int exp_ord [4] = '{1, 3, 5, 1};
        int n      = 0;
        bit raised = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_div_i[1*DW +: DW] = 8'd2;
        req_div_i[3*DW +: DW] = 8'd2;
        req_div_i[5*DW +: DW] = 8'd2;
        req_valid_i = 6'b101010;
        for (int k = 1; k <= 200; k++) begin
            step();
            for (int i = 0; i < 6; i++) begin
                if (req_ready_o[i] === 1'b1) begin
                    if (n < 4) ord[n] = i;
                    n++;
                    req_valid_i[i] = 1'b0;
                end
            end
            if (!raised && n == 1 && busy_o === 1'b1 && active_dom_o === 3'd3) begin
                req_valid_i[1] = 1'b1;
                raised = 1'b1;
            end
            if (n >= 4) break;
        end
        vectors++;
        if (n != 4) begin
            miscompares++; $display("FAIL contention_count: got %0d exp 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                vectors++;
                if (ord[i] != exp_ord[i]) begin
                    miscompares++; $display("FAIL contention_order[%0d]: got %0d exp %0d", i, ord[i], exp_ord[i]);
                end
            end
        end
        req_valid_i = '0;
        step();
    endtask

    task automatic test_illegal_div();
        logic [N-1:0] clk_en_before;
        clk_en_before        = clk_en_o;
        req_div_i[4*DW +: DW] = 8'd0;
        req_valid_i[4]       = 1'b1;
        step();
        vectors++;
        if (err_o !== 1'b1 || req_ready_o !== 6'b010000) begin
            miscompares++; $display("FAIL illegal_pulse: got err=%b ready=%h exp err=1 ready=10", err_o, req_ready_o);
        end
        vectors++;
        if (clk_en_o !== clk_en_before || div_o[4*DW +: DW] !== 8'd1) begin
            miscompares++;
            $display("FAIL illegal_no_change: got clk_en=%h div4=%0d exp clk_en=%h div4=1", clk_en_o, div_o[4*DW +: DW], clk_en_before);
        end
        req_valid_i[4] = 1'b0;
        step();
        vectors++;
        if (err_o !== 1'b0 || req_ready_o !== 6'h00 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_after: got err=%b ready=%h busy=%b exp 0 00 0", err_o, req_ready_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int rdy_k  = -1;
        int vcnt   = 0;
        int vdrop  = -1;
        div_ready_i[2]        = 1'b0;
        req_div_i[2*DW +: DW] = 8'd5;
        req_valid_i[2]        = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (div_valid_o[2] === 1'b1) vcnt++;
            if (k == 24) begin
                vectors++;
                if (div_o[2*DW +: DW] !== 8'd5 || div_valid_o[2] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL backpressure_held: got div=%0d valid=%b exp div=5 valid=1", div_o[2*DW +: DW], div_valid_o[2]);
                end
                div_ready_i[2] = 1'b1;
            end
            if (k == 25) vdrop = div_valid_o[2];
            if (req_ready_o[2] === 1'b1) begin
                rdy_k = k;
                req_valid_i[2] = 1'b0;
                break;
            end
        end
        vectors++;
        if (vcnt != 20) begin
            miscompares++; $display("FAIL backpressure_valid_cycles: got %0d exp 20", vcnt);
        end
        vectors++;
        if (vdrop != 0) begin
            miscompares++; $display("FAIL backpressure_valid_drop: got %0d exp 0", vdrop);
        end
        vectors++;
        if (rdy_k != 29) begin
            miscompares++; $display("FAIL backpressure_ready_latency: got %0d exp 29", rdy_k);
        end
        step();
    endtask

    task automatic test_rst_mid();
        logic [N*DW-1:0] exp_div;
        exp_div = {6{8'd1}};
        div_ready_i[3]        = 1'b0;
        req_div_i[3*DW +: DW] = 8'd4;
        req_valid_i[3]        = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        vectors++;
        if (div_valid_o[3] !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_in_cfg: got valid=%b exp 1", div_valid_o[3]);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_valid_i[3] = 1'b0;
        div_ready_i    = '1;
        vectors++;
        if (clk_en_o !== 6'h00 || dom_rst_o !== 6'h3f || div_o !== exp_div) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got clk_en=%h rst=%h div=%h exp 00 3f %h", clk_en_o, dom_rst_o, div_o, exp_div);
        end
        vectors++;
        if ({div_valid_o, req_ready_o, busy_o, active_dom_o, err_o} !== 17'h0) begin
            miscompares++;
            $display("FAIL rstmid_misc: got valid=%h ready=%h busy=%b dom=%0d err=%b exp all 0",
                     div_valid_o, req_ready_o, busy_o, active_dom_o, err_o);
        end
        step();
        vectors++;
        if (req_ready_o !== 6'h00 || busy_o !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_no_ready: got ready=%h busy=%b exp 00 0", req_ready_o, busy_o);
        end
    endtask

`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int err_k = -1;
        logic [2:0] snap;
        snap = '0;
        div_ready_i[1]        = 1'b0;
        req_div_i[1*DW +: DW] = 8'd7;
        req_valid_i[1]        = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (err_o === 1'b1) begin
                err_k = k;
                snap  = {clk_en_o[1], req_ready_o[1], div_valid_o[1]};
                req_valid_i[1] = 1'b0;
                break;
            end
        end
        div_ready_i = '1;
        vectors++;
        if (err_k != 21) begin
            miscompares++; $display("FAIL timeout_latency: got %0d exp 21", err_k);
        end
        vectors++;
        if (snap !== 3'b110) begin
            miscompares++; $display("FAIL timeout_outputs: got clk_en/ready/valid=%b exp 110", snap);
        end
        step();
    endtask
`endif

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_div_i   = {6{8'd1}};
        req_rst_i   = '0;
        div_ready_i = '1;
        test_reset();
        test_single();
        test_rst_bringup();
        test_contention();
        test_illegal_div();
        test_backpressure();
        test_rst_mid();
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion exp completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
